// File: rtl/raizing_gfx_pkg.sv
// Shared types and default widths for the two-channel graphics ROM responder.
package raizing_gfx_pkg;
  localparam int ADDR_W_DEF = 22;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
endpackage

// File: rtl/raizing_gfx_arb.sv
// Two-way request arbiter: a lone pending channel always wins, a tie goes to prio.
module raizing_gfx_arb (
  input  logic [1:0] pending,
  input  logic       prio,
  output logic       grant,
  output logic       grant_vld
);
  assign grant_vld = |pending;
  assign grant     = (&pending) ? prio : pending[1];
endmodule

// File: rtl/raizing_gfx_rom_responder.sv
// Two graphics channels sharing one memory read port, each with a one-word cache.
// Define RAIZING_GFX_ROUNDROBIN_EN to alternate priority on every fill; otherwise channel 0 wins ties.
module raizing_gfx_rom_responder
  import raizing_gfx_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        gfx_cs,
  input  logic [ADDR_W-1:0] gfx0_addr,
  input  logic [ADDR_W-1:0] gfx1_addr,
  output logic [1:0]        gfx_ok,
  output logic [DATA_W-1:0] gfx0_dout,
  output logic [DATA_W-1:0] gfx1_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_din,
  input  logic              mem_rdy
);
  state_t                   state;
  logic                     grant, grant_vld, grant_q, prio;
  logic [1:0]               valid, pending;
  logic [1:0][ADDR_W-1:0]   addr, tag;
  logic [1:0][DATA_W-1:0]   data;

  assign addr      = {gfx1_addr, gfx0_addr};
  assign gfx_ok[0] = gfx_cs[0] & valid[0] & (addr[0] == tag[0]);
  assign gfx_ok[1] = gfx_cs[1] & valid[1] & (addr[1] == tag[1]);
  assign pending   = gfx_cs & ~gfx_ok;
  assign gfx0_dout = data[0];
  assign gfx1_dout = data[1];

  raizing_gfx_arb u_arb (
    .pending   (pending),
    .prio      (prio),
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  // The fill writes tag from mem_addr, not the live channel address, so an
  // address change mid-read leaves the channel missing and it re-requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      grant_q  <= 1'b0;
      prio     <= 1'b0;
      valid    <= '0;
      tag      <= '0;
      data     <= '0;
    end else begin
      case (state)
        IDLE: if (grant_vld) begin
          grant_q  <= grant;
          mem_addr <= addr[grant];
          mem_rd   <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: begin
          mem_rd <= 1'b0;
          state  <= WAIT;
        end
        WAIT: if (mem_rdy) begin
          data[grant_q]  <= mem_din;
          tag[grant_q]   <= mem_addr;
          valid[grant_q] <= 1'b1;
`ifdef RAIZING_GFX_ROUNDROBIN_EN
          prio           <= ~prio;
`endif
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_raizing_gfx_rom_responder.sv
// Bench: transaction-level model of the two one-word caches and the single outstanding read.
module tb_raizing_gfx_rom_responder;
  localparam int AW = 22;
  localparam int DW = 32;

  logic          clk = 1'b0, reset = 1'b1;
  logic [1:0]    gfx_cs = '0;
  logic [AW-1:0] gfx0_addr = '0, gfx1_addr = '0;
  logic [1:0]    gfx_ok;
  logic [DW-1:0] gfx0_dout, gfx1_dout;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [DW-1:0] mem_din = '0;
  logic          mem_rdy = 1'b0;

  always #5 clk = ~clk;

  raizing_gfx_rom_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .gfx_cs(gfx_cs), .gfx0_addr(gfx0_addr), .gfx1_addr(gfx1_addr),
    .gfx_ok(gfx_ok), .gfx0_dout(gfx0_dout), .gfx1_dout(gfx1_dout), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_din(mem_din), .mem_rdy(mem_rdy)
  );

  int checks = 0, errors = 0, cyc = 0;

  // model: cached words plus at most one outstanding read
  bit            m_valid [2];
  logic [AW-1:0] m_tag [2];
  logic [DW-1:0] m_data [2];
  bit            busy = 0, m_prio = 0, grant_now = 0, fill_now = 0;
  int            rd_cycle = -1, rdy_cycle = -1, rch = 0, gch = 0;
  logic [AW-1:0] raddr = '0, gaddr = '0, m_mem_addr = '0;
  logic [DW-1:0] fdin = '0;

  // knobs
  int            lat_fix = 0;
  bit            data_fix_en = 0, spur_en = 0, inj_rdy = 0, rst_knob = 1;
  logic [DW-1:0] data_fix = '0;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return DW'(a) * 32'h9E3779B1 ^ 32'h5A5A5A5A;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] cs, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    logic [1:0]    eok, pend;
    logic [AW-1:0] a [2];
    @(posedge clk);
    cyc++;
    if (fill_now) begin
      m_valid[rch] = 1; m_tag[rch] = raddr; m_data[rch] = fdin; busy = 0;
`ifdef RAIZING_GFX_ROUNDROBIN_EN
      m_prio = !m_prio;
`endif
    end
    if (grant_now) begin
      busy = 1; rch = gch; raddr = gaddr; m_mem_addr = gaddr; rd_cycle = cyc;
      rdy_cycle = cyc + ((lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4)));
    end
    fill_now = 0; grant_now = 0;
    #1;
    gfx_cs = cs; gfx0_addr = a0; gfx1_addr = a1; reset = rst_knob;
    if (rst_knob) begin
      for (int i = 0; i < 2; i++) begin m_valid[i] = 0; m_tag[i] = '0; m_data[i] = '0; end
      busy = 0; m_prio = 0; m_mem_addr = '0;
    end
    mem_rdy = 0; mem_din = $urandom;
    if (busy && cyc == rdy_cycle) begin
      mem_rdy = 1; mem_din = data_fix_en ? data_fix : memf(raddr);
    end else if (!(busy && cyc > rd_cycle) && (inj_rdy || (spur_en && $urandom_range(0, 3) == 0)))
      mem_rdy = 1;
    a[0] = a0; a[1] = a1;
    for (int i = 0; i < 2; i++) begin
      eok[i]  = cs[i] && m_valid[i] && (a[i] == m_tag[i]);
      pend[i] = cs[i] && !eok[i];
    end
    fill_now = busy && cyc > rd_cycle && mem_rdy;
    fdin = mem_din;
    if (!busy && !rst_knob && pend != 2'b00) begin
      gch = (pend == 2'b11) ? int'(m_prio) : (pend[0] ? 0 : 1);
      gaddr = a[gch]; grant_now = 1;
    end
    @(negedge clk);
    chk("gfx_ok", gfx_ok, eok);
    chk("gfx0_dout", gfx0_dout, m_data[0]);
    chk("gfx1_dout", gfx1_dout, m_data[1]);
    chk("mem_rd", mem_rd, busy && cyc == rd_cycle);
    chk("mem_addr", mem_addr, m_mem_addr);
  endtask

  task automatic do_reset();
    rst_knob = 1;
    step(2'b00, '0, '0);
    step(2'b00, '0, '0);
    rst_knob = 0;
  endtask

  logic [1:0]    rcs;
  logic [AW-1:0] ra0, ra1;

  initial begin
    do_reset();
    chk("rst_ok", gfx_ok, 2'b00);
    chk("rst_dout0", gfx0_dout, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // single miss, memory answers 3 cycles after the read strobe
    lat_fix = 3; data_fix_en = 1; data_fix = 32'hDEADBEEF;
    for (int i = 0; i <= 5; i++) begin
      step(2'b01, 22'h000100, '0);
      if (i == 0) chk("r32_rd0", mem_rd, 0);
      if (i == 1) chk("r32_rd1", mem_rd, 1);
      if (i == 1) chk("r32_addr", mem_addr, 22'h000100);
      if (i == 4) chk("r32_ok4", gfx_ok, 2'b00);
      if (i == 5) chk("r32_ok5", gfx_ok, 2'b01);
      if (i == 5) chk("r32_dout", gfx0_dout, 32'hDEADBEEF);
    end
    data_fix_en = 0;

    // simultaneous misses
    do_reset();
    lat_fix = 1;
    for (int i = 0; i <= 13; i++) begin
      if (i <= 6) step(2'b11, 22'h10, 22'h20);
      else        step(2'b11, 22'h30, 22'h40);
      if (i == 1) chk("r33_first", mem_addr, 22'h10);
      if (i == 4) chk("r33_second", mem_addr, 22'h20);
      if (i == 6) chk("r33_both_ok", gfx_ok, 2'b11);
`ifndef RAIZING_GFX_ROUNDROBIN_EN
      if (i == 8) chk("r33_again_ch0", mem_addr, 22'h30);
`endif
      if (i == 13) chk("r33_both_ok2", gfx_ok, 2'b11);
    end

    // address moves during the read
    do_reset();
    lat_fix = 3;
    for (int i = 0; i <= 10; i++) begin
      step(2'b01, (i < 2) ? 22'h10 : 22'h11, '0);
      if (i == 5) chk("r34_ok_low", gfx_ok, 2'b00);
      if (i == 6) chk("r34_rerd", mem_rd, 1);
      if (i == 6) chk("r34_readdr", mem_addr, 22'h11);
      if (i == 10) chk("r34_ok", gfx_ok, 2'b01);
    end

    // hit on an address already in the tag
    step(2'b01, 22'h11, '0);
    chk("r35_hit", gfx_ok, 2'b01);
    step(2'b01, 22'h11, '0);
    chk("r35_no_rd", mem_rd, 0);

    // reset in the middle of a read, stale data pulse afterwards
    do_reset();
    lat_fix = 6;
    for (int i = 0; i <= 8; i++) begin
      rst_knob = (i == 3 || i == 4);
      inj_rdy  = (i == 7);
      step((i < 3 || i == 8) ? 2'b01 : 2'b00, 22'h40, '0);
      if (i == 7) chk("r36_rd", mem_rd, 0);
      if (i == 8) chk("r36_ok", gfx_ok, 2'b00);
      if (i == 8) chk("r36_dout", gfx0_dout, 0);
    end
    rst_knob = 0; inj_rdy = 0;

    // randomized traffic over a small address pool
    lat_fix = 0; spur_en = 1;
    rcs = 2'b00; ra0 = '0; ra1 = '0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) rcs = 2'($urandom);
      if ($urandom_range(0, 5) == 0) ra0 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) ra1 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      rst_knob = ($urandom_range(0, 399) == 0);
      step(rcs, ra0, ra1);
    end
    rst_knob = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
